// File: rtl/mips_multicycle_ctrl_if.sv
// Bundle between the multicycle MIPS control FSM and its datapath: instruction
// fields and memory handshake in, mux selects and write enables out.
interface mips_multicycle_ctrl_if;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
  logic       MemReady;
  logic       IorD;
  logic       MemWrite;
  logic       IRWrite;
  logic       PCEn;
  logic [1:0] PCSrc;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;
  logic       RegWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       Illegal;
  logic [3:0] State;

  modport master (
    input  Op, Funct, Zero, MemReady,
    output IorD, MemWrite, IRWrite, PCEn, PCSrc, ALUSrcA, ALUSrcB,
           ALUControl, RegWrite, RegDst, MemtoReg, Illegal, State
  );

  modport slave (
    output Op, Funct, Zero, MemReady,
    input  IorD, MemWrite, IRWrite, PCEn, PCSrc, ALUSrcA, ALUSrcB,
           ALUControl, RegWrite, RegDst, MemtoReg, Illegal, State
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Moore control FSM for a multicycle MIPS datapath sharing one memory port.
// Optional bne support is enabled by defining MC_BNE_EN.
module mips_multicycle_ctrl (
  input logic                    CLK,
  input logic                    reset,
  mips_multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;

  function automatic logic [2:0] alu_decode(input logic [5:0] funct);
    case (funct)
      6'b100000: alu_decode = 3'b010;
      6'b100010: alu_decode = 3'b110;
      6'b100100: alu_decode = 3'b000;
      6'b100101: alu_decode = 3'b001;
      6'b101010: alu_decode = 3'b111;
      default:   alu_decode = 3'b010;
    endcase
  endfunction

  state_t state, state_nxt;

  logic       iord, memwrite, irwrite, pcen;
  logic [1:0] pcsrc;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [2:0] aluctl;
  logic       regwrite, regdst, memtoreg, illegal;

  always_ff @(posedge CLK) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nxt;
  end

`ifdef MC_BNE_EN
  // Op may change once the branch is under way, so the condition sense is latched here.
  logic is_bne;
  always_ff @(posedge CLK) begin
    if (state == S_DECODE) is_bne <= (bus.Op == OP_BNE);
  end
`endif

  always_comb begin
    state_nxt = state;
    iord      = 1'b0;
    memwrite  = 1'b0;
    irwrite   = 1'b0;
    pcen      = 1'b0;
    pcsrc     = 2'b00;
    alusrca   = 1'b0;
    alusrcb   = 2'b00;
    aluctl    = 3'b000;
    regwrite  = 1'b0;
    regdst    = 1'b0;
    memtoreg  = 1'b0;
    illegal   = 1'b0;
    case (state)
      S_FETCH: begin
        alusrcb = 2'b01;
        aluctl  = ALU_ADD;
        irwrite = bus.MemReady;
        pcen    = bus.MemReady;
        if (bus.MemReady) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        aluctl  = ALU_ADD;
        case (bus.Op)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_RTYPE:     state_nxt = S_EXECUTE;
          OP_BEQ:       state_nxt = S_BRANCH;
`ifdef MC_BNE_EN
          OP_BNE:       state_nxt = S_BRANCH;
`endif
          OP_ADDI:      state_nxt = S_ADDIEX;
          OP_J:         state_nxt = S_JUMP;
          default: begin
            state_nxt = S_FETCH;
            illegal   = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca   = 1'b1;
        alusrcb   = 2'b10;
        aluctl    = ALU_ADD;
        state_nxt = (bus.Op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord = 1'b1;
        if (bus.MemReady) state_nxt = S_MEMWB;
      end
      S_MEMWB: begin
        regwrite  = 1'b1;
        memtoreg  = 1'b1;
        state_nxt = S_FETCH;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
        if (bus.MemReady) state_nxt = S_FETCH;
      end
      S_EXECUTE: begin
        alusrca   = 1'b1;
        aluctl    = alu_decode(bus.Funct);
        state_nxt = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite  = 1'b1;
        regdst    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_BRANCH: begin
        alusrca   = 1'b1;
        aluctl    = ALU_SUB;
        pcsrc     = 2'b01;
`ifdef MC_BNE_EN
        pcen      = is_bne ? ~bus.Zero : bus.Zero;
`else
        pcen      = bus.Zero;
`endif
        state_nxt = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca   = 1'b1;
        alusrcb   = 2'b10;
        aluctl    = ALU_ADD;
        state_nxt = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite  = 1'b1;
        state_nxt = S_FETCH;
      end
      S_JUMP: begin
        pcsrc     = 2'b10;
        pcen      = 1'b1;
        state_nxt = S_FETCH;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  assign bus.IorD       = iord;
  assign bus.MemWrite   = memwrite;
  assign bus.IRWrite    = irwrite;
  assign bus.PCEn       = pcen;
  assign bus.PCSrc      = pcsrc;
  assign bus.ALUSrcA    = alusrca;
  assign bus.ALUSrcB    = alusrcb;
  assign bus.ALUControl = aluctl;
  assign bus.RegWrite   = regwrite;
  assign bus.RegDst     = regdst;
  assign bus.MemtoReg   = memtoreg;
  assign bus.Illegal    = illegal;
  assign bus.State      = state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized instruction-stream bench for mips_multicycle_ctrl, checked against
// an instruction-level model of the expected state walk and per-state outputs.
module tb_mips_multicycle_ctrl;

  logic CLK = 1'b0;
  logic reset;
  mips_multicycle_ctrl_if bus ();

  mips_multicycle_ctrl dut (.CLK(CLK), .reset(reset), .bus(bus));

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  localparam int FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5,
                 EXECUTE = 6, ALUWB = 7, BRANCH = 8, ADDIEX = 9, ADDIWB = 10, JUMP = 11;

  // {State, Illegal, MemtoReg, RegDst, RegWrite, ALUControl, ALUSrcB, ALUSrcA, PCSrc, PCEn, IRWrite, MemWrite, IorD}
  function automatic logic [19:0] observed();
    return {bus.State, bus.Illegal, bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ALUControl,
            bus.ALUSrcB, bus.ALUSrcA, bus.PCSrc, bus.PCEn, bus.IRWrite, bus.MemWrite, bus.IorD};
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
`ifdef MC_BNE_EN
    return op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010, 6'b000101};
`else
    return op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
`endif
  endfunction

  function automatic logic [2:0] funct_alu(input logic [5:0] f);
    if (f == 6'b100010) return 3'b110;
    if (f == 6'b100100) return 3'b000;
    if (f == 6'b100101) return 3'b001;
    if (f == 6'b101010) return 3'b111;
    return 3'b010;
  endfunction

  // Expected datapath controls for one cycle of a given state.
  function automatic logic [19:0] expect_vec(input int st, input bit mr, input logic [5:0] op,
                                             input logic [5:0] fn, input bit z);
    logic iord = 0, mw = 0, irw = 0, pce = 0, srca = 0, rw = 0, rd = 0, m2r = 0, ill = 0;
    logic [1:0] pcs = 0, srcb = 0;
    logic [2:0] alu = 0;
    logic [3:0] s4 = st[3:0];
    case (st)
      FETCH:   begin srcb = 2'b01; alu = 3'b010; irw = mr; pce = mr; end
      DECODE:  begin srcb = 2'b11; alu = 3'b010; ill = !is_legal(op); end
      MEMADR:  begin srca = 1; srcb = 2'b10; alu = 3'b010; end
      MEMRD:   iord = 1;
      MEMWB:   begin rw = 1; m2r = 1; end
      MEMWR:   begin iord = 1; mw = 1; end
      EXECUTE: begin srca = 1; alu = funct_alu(fn); end
      ALUWB:   begin rw = 1; rd = 1; end
      BRANCH:  begin srca = 1; alu = 3'b110; pcs = 2'b01; pce = (op == 6'b000101) ? !z : z; end
      ADDIEX:  begin srca = 1; srcb = 2'b10; alu = 3'b010; end
      ADDIWB:  rw = 1;
      JUMP:    begin pcs = 2'b10; pce = 1; end
      default: ;
    endcase
    return {s4, ill, m2r, rd, rw, alu, srcb, srca, pcs, pce, irw, mw, iord};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Runs one instruction: fs stall cycles in FETCH, ms stall cycles in MEMRD/MEMWR.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input bit z,
                           input int fs, input int ms);
    int sq[$];
    bit mq[$];
    for (int i = 0; i < fs; i++) begin sq.push_back(FETCH); mq.push_back(1'b0); end
    sq.push_back(FETCH);  mq.push_back(1'b1);
    sq.push_back(DECODE); mq.push_back(1'($urandom_range(0, 1)));
    if (op == 6'b100011 || op == 6'b101011) begin
      int ms_st = (op == 6'b100011) ? MEMRD : MEMWR;
      sq.push_back(MEMADR); mq.push_back(1'($urandom_range(0, 1)));
      for (int i = 0; i < ms; i++) begin sq.push_back(ms_st); mq.push_back(1'b0); end
      sq.push_back(ms_st); mq.push_back(1'b1);
      if (op == 6'b100011) begin sq.push_back(MEMWB); mq.push_back(1'($urandom_range(0, 1))); end
    end else if (is_legal(op)) begin
      case (op)
        6'b000000: begin sq.push_back(EXECUTE); sq.push_back(ALUWB); end
        6'b001000: begin sq.push_back(ADDIEX);  sq.push_back(ADDIWB); end
        6'b000010: sq.push_back(JUMP);
        default:   sq.push_back(BRANCH);
      endcase
      while (mq.size() < sq.size()) mq.push_back(1'($urandom_range(0, 1)));
    end
    foreach (sq[i]) begin
      bus.Op       = op;
      bus.Funct    = fn;
      bus.MemReady = mq[i];
      bus.Zero     = (sq[i] == BRANCH) ? z : 1'($urandom_range(0, 1));
      @(negedge CLK);
      check($sformatf("op%b_st%0d_cyc%0d", op, sq[i], i), {12'd0, observed()},
            {12'd0, expect_vec(sq[i], mq[i], op, fn, z)});
      @(posedge CLK); #1;
    end
  endtask

  localparam logic [5:0] OPS [8] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                                     6'b001000, 6'b000010, 6'b000101, 6'b111111};
  localparam logic [5:0] FNS [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                     6'b101010, 6'b000111};

  initial begin
    bus.Op = 6'b0; bus.Funct = 6'b0; bus.Zero = 1'b0; bus.MemReady = 1'b1;
    reset = 1'b1;
    @(posedge CLK); #1;
    @(negedge CLK);
    check("reset_state", {28'd0, bus.State}, 32'd0);
    @(posedge CLK); #1;
    reset = 1'b0;

    // First fetch after release: State 0 with IRWrite=PCEn=1.
    run_instr(6'b100011, 6'b0, 1'b0, 0, 0);
    run_instr(6'b101011, 6'b0, 1'b0, 0, 3);
    run_instr(6'b000000, 6'b101010, 1'b0, 0, 0);
    run_instr(6'b000100, 6'b0, 1'b1, 0, 0);
    run_instr(6'b000100, 6'b0, 1'b0, 0, 0);
    run_instr(6'b000101, 6'b0, 1'b0, 0, 0);
    run_instr(6'b000101, 6'b0, 1'b1, 1, 0);
    run_instr(6'b001000, 6'b0, 1'b0, 2, 0);
    run_instr(6'b000010, 6'b0, 1'b0, 0, 0);
    run_instr(6'b100011, 6'b0, 1'b0, 1, 2);

    for (int n = 0; n < 40; n++) begin
      logic [5:0] op, fn;
      op = OPS[$urandom_range(0, 7)];
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : FNS[$urandom_range(0, 5)];
      if (op == 6'b111111) op = 6'($urandom);
      run_instr(op, fn, 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 3));
    end

    // Reset in MEMRD while the memory is stalling.
    bus.Op = 6'b100011; bus.MemReady = 1'b1;
    repeat (3) begin @(posedge CLK); #1; end
    bus.MemReady = 1'b0;
    @(negedge CLK);
    check("memrd_wait_state", {28'd0, bus.State}, 32'd3);
    reset = 1'b1;
    @(posedge CLK); #1;
    @(negedge CLK);
    check("midwait_reset_state", {28'd0, bus.State}, 32'd0);
    check("midwait_reset_regwrite", {31'd0, bus.RegWrite}, 32'd0);
    reset = 1'b0;
    @(posedge CLK); #1;
    run_instr(6'b000010, 6'b0, 1'b0, 1, 0);
    bus.MemReady = 1'b0;
    @(negedge CLK);
    check("final_fetch", {12'd0, observed()}, {12'd0, expect_vec(FETCH, 1'b0, 6'b0, 6'b0, 1'b0)});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Moore-style control FSM that sequences a multicycle MIPS datapath. It replaces the single-cycle combinational control unit when instructions and data share one memory port. The block steps each instruction through fetch, decode, execute, memory and writeback states, and stalls on a memory-ready handshake. It sits between the instruction register (opcode and funct fields, ALU Zero flag) and the datapath multiplexers and write enables.

## Interface
- No parameters.
- CLK  in  1  single clock; all state updates occur on the rising edge.
- reset  in  1  synchronous, active-high; forces the state to FETCH.
- Op  in  6  instruction register bits [31:26].
- Funct  in  6  instruction register bits [5:0].
- Zero  in  1  ALU zero flag, valid in the BRANCH state.
- MemReady  in  1  shared memory has completed the current access this cycle.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  instruction register load.
- PCEn  out  1  PC load, equal to PCWrite | (Branch & branch condition).
- PCSrc  out  2  next-PC select: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- ALUSrcA  out  1  ALU operand A select: 0 = PC, 1 = register A.
- ALUSrcB  out  2  ALU operand B select: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- ALUControl  out  3  ALU operation.
- RegWrite  out  1  register file write enable.
- RegDst  out  1  write register select: 0 = rt, 1 = rd.
- MemtoReg  out  1  writeback data select: 0 = ALUOut, 1 = memory data.
- Illegal  out  1  one-cycle pulse in DECODE when the opcode is unsupported.
- State  out  4  current state encoding, for debug.

## Operation
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
- Any output not listed for a state is 0.
- FETCH: ALUSrcB=01, ALUControl=add (010). IRWrite=PCEn=MemReady. Stay in FETCH while MemReady=0; go to DECODE when MemReady=1.
- DECODE: ALUSrcB=11, ALUControl=add (computes the branch target). Next state by Op:
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 000000 (R-type) -> EXECUTE
  - 000100 (beq) -> BRANCH
  - 001000 (addi) -> ADDIEX
  - 000010 (j) -> JUMP
  - any other opcode -> FETCH with Illegal=1; the instruction executes as a NOP.
- MEMADR: ALUSrcA=1, ALUSrcB=10, add. Next is MEMRD for lw, MEMWR for sw.
- MEMRD: IorD=1. Wait while MemReady=0, then go to MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Then FETCH.
- MEMWR: IorD=1, MemWrite=1. Hold until MemReady=1, then go to FETCH.
- EXECUTE: ALUSrcA=1, ALUSrcB=00. ALUControl decoded from Funct:
  - 100000 -> 010 (add)
  - 100010 -> 110 (sub)
  - 100100 -> 000 (and)
  - 100101 -> 001 (or)
  - 101010 -> 111 (slt)
  - any other Funct -> 010 (add).
- ALUWB: RegWrite=1, RegDst=1. Then FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUControl=110 (sub), PCSrc=01, PCEn=Zero. Then FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, add. Then ADDIWB.
- ADDIWB: RegWrite=1, RegDst=0. Then FETCH.
- JUMP: PCSrc=10, PCEn=1. Then FETCH.
- Outputs are decoded from State, except that PCEn, IRWrite and MemWrite-qualified transitions depend on MemReady and Zero combinationally.

## Timing
- Reset: the state is FETCH on the edge where reset=1. Reset takes priority over every transition, including mid-instruction and mid-wait.
- Outputs while in FETCH with MemReady=0: all enables 0, ALUSrcB=01, ALUControl=010.
- Cycle counts per instruction with MemReady held at 1:
  - lw: 5
  - sw: 4
  - R-type: 4
  - addi: 4
  - beq: 3
  - j: 3
- Each cycle with MemReady=0 in FETCH, MEMRD or MEMWR adds exactly one cycle; MemWrite stays asserted throughout the stall.
- MemReady is ignored in all other states.
- Zero is sampled only in BRANCH.

## Configuration
- MC_BNE_EN defined: opcode 000101 (bne) moves from DECODE to BRANCH. In BRANCH, PCEn = ~Zero for bne and Zero for beq. The opcode is registered in DECODE to select the condition.
- MC_BNE_EN undefined: opcode 000101 is illegal (Illegal=1, return to FETCH).

## Test plan
- Reset held for 2 cycles with MemReady=1, then released -> State=0 on release; IRWrite=1 and PCEn=1 on the first cycle.
- lw (Op=100011) with MemReady=1 -> State sequence 0,1,2,3,4,0. RegWrite=1 and MemtoReg=1 only in state 4.
- sw with MemReady=0 for 3 cycles in MEMWR -> MemWrite=1 for 4 consecutive cycles, then State=0.
- R-type with Funct=101010 -> ALUControl=111 in EXECUTE; RegWrite=1 with RegDst=1 in ALUWB.
- beq with Zero=1 -> PCEn=1 and PCSrc=01 in BRANCH. With Zero=0 -> PCEn=0. Opcode 000101 -> Illegal=1 without MC_BNE_EN; with MC_BNE_EN and Zero=0 -> PCEn=1.
- reset asserted while State=3 and MemReady=0 -> State=0 on the next edge, with no RegWrite pulse.
